// File: rtl/sid_envelope_pkg.sv
// Shared SID types and constants used by the envelope generator: phase strobe, register group,
// envelope state encoding, rate period table and exponential-decay breakpoints.
package sid;

  localparam int unsigned PHI1 = 0;
  localparam int unsigned PHI2 = 1;

  typedef logic [1:0]  phase_t;
  typedef logic [7:0]  reg8_t;
  typedef logic [14:0] reg15_t;
  typedef logic [3:0]  nibble_t;

  typedef struct packed {
    logic    gate;
    nibble_t attack;
    nibble_t decay;
    nibble_t sustain;
    nibble_t release_;
  } envelope_reg_t;

  typedef enum logic [1:0] {
    ATTACK        = 2'd0,
    DECAY_SUSTAIN = 2'd1,
    RELEASE       = 2'd2
  } env_state_e;

  localparam reg15_t RATE_PERIOD [16] = '{
    15'd9,    15'd32,   15'd63,    15'd95,    15'd149,   15'd220,   15'd267,   15'd313,
    15'd392,  15'd977,  15'd1954,  15'd3126,  15'd3907,  15'd11720, 15'd19532, 15'd31251
  };

  localparam reg8_t EXP_BP_P1_TOP = 8'hFF;
  localparam reg8_t EXP_BP_P2     = 8'h5D;
  localparam reg8_t EXP_BP_P4     = 8'h36;
  localparam reg8_t EXP_BP_P8     = 8'h1A;
  localparam reg8_t EXP_BP_P16    = 8'h0E;
  localparam reg8_t EXP_BP_P30    = 8'h06;
  localparam reg8_t EXP_BP_P1_BOT = 8'h00;

  // Period only moves when the level lands exactly on a breakpoint; otherwise it is kept.
  function automatic reg8_t exp_period_next(reg8_t level, reg8_t cur);
    case (level)
      EXP_BP_P1_TOP: return 8'd1;
      EXP_BP_P2:     return 8'd2;
      EXP_BP_P4:     return 8'd4;
      EXP_BP_P8:     return 8'd8;
      EXP_BP_P16:    return 8'd16;
      EXP_BP_P30:    return 8'd30;
      EXP_BP_P1_BOT: return 8'd1;
      default:       return cur;
    endcase
  endfunction

endpackage

// File: rtl/sid_envelope_if.sv
// Envelope voice bundle: phase strobe and register group in, level and debug state out.
interface sid_envelope_if;
  import sid::*;

  phase_t        phase;
  envelope_reg_t regs;
  reg8_t         env;
  logic [1:0]    state_o;

  modport master (output phase, output regs, input env, input state_o);
  modport slave  (input phase, input regs, output env, output state_o);

endinterface

// File: rtl/sid_env_rate_counter.sv
// 15-bit envelope rate prescaler; emits a one-tick step strobe when the count hits the period.
module sid_env_rate_counter
  import sid::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    tick_i,
  input  nibble_t rate_i,
  output logic    step_o
);

  reg15_t cnt_q, cnt_d;
  reg15_t cnt_inc;

  // Equality compare only: a period lowered below the count waits for the 15-bit wrap.
  always_comb begin
    cnt_inc = cnt_q + 15'd1;
    step_o  = tick_i && (cnt_inc == RATE_PERIOD[rate_i]);
    cnt_d   = cnt_q;
    if (tick_i) begin
      cnt_d = step_o ? '0 : cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sid_envelope.sv
// Per-voice ADSR envelope generator: gate edge detection, attack/decay/release stepping and
// the piecewise exponential decay divider.
module sid_envelope
  import sid::*;
#(
  parameter bit HOLD_ZERO = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  sid_envelope_if.slave       bus
);

  env_state_e state_q, state_d, state_g;
  reg8_t      env_q, env_d;
  reg8_t      exp_cnt_q, exp_cnt_d;
  reg8_t      exp_per_q, exp_per_d;
  logic       hold_zero_q, hold_zero_d, hold_zero_g;
  logic       gate_q, gate_d;

  logic       tick;
  logic       rate_step;
  nibble_t    rate_nib;
  reg8_t      env_new;
  reg8_t      exp_inc;
  reg8_t      sustain_lvl;
  logic       env_chg;
  logic       unused_phi1;

  assign tick        = bus.phase[PHI2];
  assign unused_phi1 = bus.phase[PHI1];
  assign sustain_lvl = {bus.regs.sustain, bus.regs.sustain};

  // Gate edges resolve first so that a rate step in the same tick sees the new state.
  always_comb begin
    state_g     = state_q;
    hold_zero_g = hold_zero_q;
    if (tick) begin
      if (bus.regs.gate && !gate_q) begin
        state_g     = ATTACK;
        hold_zero_g = 1'b0;
      end else if (!bus.regs.gate && gate_q) begin
        state_g = RELEASE;
      end
    end
    case (state_g)
      ATTACK:        rate_nib = bus.regs.attack;
      DECAY_SUSTAIN: rate_nib = bus.regs.decay;
      default:       rate_nib = bus.regs.release_;
    endcase
  end

  sid_env_rate_counter u_rate (
    .clk    (clk),
    .rst    (rst),
    .tick_i (tick),
    .rate_i (rate_nib),
    .step_o (rate_step)
  );

  always_comb begin
    state_d     = state_g;
    hold_zero_d = hold_zero_g;
    env_d       = env_q;
    exp_cnt_d   = exp_cnt_q;
    exp_per_d   = exp_per_q;
    gate_d      = tick ? bus.regs.gate : gate_q;
    env_new     = env_q;
    env_chg     = 1'b0;
    exp_inc     = exp_cnt_q + 8'd1;

    if (rate_step) begin
      if (state_g == ATTACK) begin
        exp_cnt_d = '0;
        if (!hold_zero_g && env_q != 8'hFF) begin
          env_new = env_q + 8'd1;
          env_chg = 1'b1;
        end
        if (env_new == 8'hFF) begin
          state_d = DECAY_SUSTAIN;
        end
      end else begin
        exp_cnt_d = exp_inc;
        if (exp_inc == exp_per_q) begin
          exp_cnt_d = '0;
          if (state_g == DECAY_SUSTAIN) begin
            if (env_q != sustain_lvl) begin
              env_new = env_q - 8'd1;
              env_chg = 1'b1;
            end
          end else if (env_q != 8'h00 && !hold_zero_g) begin
            env_new = env_q - 8'd1;
            env_chg = 1'b1;
          end
        end
      end
    end

    if (env_chg) begin
      env_d     = env_new;
      exp_per_d = exp_period_next(env_new, exp_per_q);
      if (env_new == 8'h00 && HOLD_ZERO) begin
        hold_zero_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RELEASE;
      env_q       <= '0;
      exp_cnt_q   <= '0;
      exp_per_q   <= 8'd1;
      hold_zero_q <= 1'b1;
      gate_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      env_q       <= env_d;
      exp_cnt_q   <= exp_cnt_d;
      exp_per_q   <= exp_per_d;
      hold_zero_q <= hold_zero_d;
      gate_q      <= gate_d;
    end
  end

  assign bus.env     = env_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_sid_envelope.sv
// Bench for sid_envelope: directed ADSR scenarios plus random traffic, scored per clock against
// a reference model of the envelope rules.
module tb_sid_envelope;
  import sid::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sid_envelope_if bus ();

  sid_envelope #(.HOLD_ZERO(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int env;
    int st;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam int S_ATT = 0;
  localparam int S_DS  = 1;
  localparam int S_REL = 2;

  int rate_tab [16] = '{9, 32, 63, 95, 149, 220, 267, 313, 392, 977, 1954, 3126, 3907, 11720,
                        19532, 31251};

  // Reference model state
  int m_env, m_st, m_rate, m_exp, m_per, m_hz, m_gate;

  logic       gate;
  logic [3:0] a_nib, d_nib, s_nib, r_nib;

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp_v);
    end
  endtask

  task automatic set_level(input int lvl);
    m_env = lvl;
    case (lvl)
      255: m_per = 1;
      93:  m_per = 2;
      54:  m_per = 4;
      26:  m_per = 8;
      14:  m_per = 16;
      6:   m_per = 30;
      0: begin
        m_per = 1;
        m_hz  = 1;
      end
      default: ;
    endcase
  endtask

  task automatic model_clock(input bit r, input bit t);
    int nib;
    if (r) begin
      m_env = 0; m_st = S_REL; m_rate = 0; m_exp = 0; m_per = 1; m_hz = 1; m_gate = 0;
      return;
    end
    if (!t) return;
    if (gate && m_gate == 0) begin
      m_st = S_ATT;
      m_hz = 0;
    end else if (!gate && m_gate == 1) begin
      m_st = S_REL;
    end
    m_gate = int'(gate);
    nib = (m_st == S_ATT) ? int'(a_nib) : (m_st == S_DS) ? int'(d_nib) : int'(r_nib);
    m_rate = (m_rate + 1) % 32768;
    if (m_rate != rate_tab[nib]) return;
    m_rate = 0;
    if (m_st == S_ATT) begin
      m_exp = 0;
      if (m_hz == 0 && m_env < 255) set_level(m_env + 1);
      if (m_env == 255) m_st = S_DS;
    end else begin
      m_exp = (m_exp + 1) % 256;
      if (m_exp == m_per) begin
        m_exp = 0;
        if (m_st == S_DS) begin
          if (m_env != int'(s_nib) * 17) set_level(m_env - 1);
        end else if (m_env > 0 && m_hz == 0) begin
          set_level(m_env - 1);
        end
      end
    end
  endtask

  // Apply one clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic drive(input bit r, input bit phi2);
    exp_t e;
    rst              = r;
    bus.phase        = phi2 ? 2'b10 : 2'b01;
    bus.regs.gate    = gate;
    bus.regs.attack  = a_nib;
    bus.regs.decay   = d_nib;
    bus.regs.sustain = s_nib;
    bus.regs.release_ = r_nib;
    model_clock(r, phi2);
    e.env = m_env;
    e.st  = m_st;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1);
  endtask

  // Monitor: outputs are valid every clock, compared one edge after they were predicted.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_env", int'(bus.env), e.env);
        check("sb_state", int'(bus.state_o), e.st);
      end
    end
  end

  initial begin
    gate = 1'b0; a_nib = '0; d_nib = '0; s_nib = '0; r_nib = '0;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    check("reset_env", int'(bus.env), 0);
    check("reset_state", int'(bus.state_o), S_REL);

    // Attack 0 to peak, then decay 0 to sustain 8
    gate = 1'b1; s_nib = 4'd8;
    ticks(8);
    check("attack_pre_first", int'(bus.env), 0);
    ticks(1);
    check("attack_first", int'(bus.env), 1);
    ticks(2294 - 9);
    check("attack_pre_peak", int'(bus.env), 8'hFE);
    ticks(1);
    check("attack_peak", int'(bus.env), 8'hFF);
    check("attack_to_decay", int'(bus.state_o), S_DS);
    ticks(1500);
    check("sustain_hold", int'(bus.env), 8'h88);
    check("sustain_state", int'(bus.state_o), S_DS);

    // Release 0 from peak down to zero, then retrigger
    drive(1'b1, 1'b1);
    s_nib = 4'hF;
    ticks(2400);
    check("peak_hold", int'(bus.env), 8'hFF);
    gate = 1'b0;
    ticks(7000);
    check("release_zero", int'(bus.env), 0);
    check("release_state", int'(bus.state_o), S_REL);
    gate = 1'b1;
    ticks(1);
    check("retrigger_state", int'(bus.state_o), S_ATT);
    ticks(20);

    // ADSR delay bug: period dropped below the running count
    drive(1'b1, 1'b1);
    a_nib = 4'd15;
    ticks(20000);
    a_nib = 4'd0;
    ticks(12776);
    check("delay_bug_pre", int'(bus.env), 0);
    ticks(1);
    check("delay_bug_step", int'(bus.env), 1);

    // Phase gating: nothing moves without PHI2
    for (int i = 0; i < 1000; i++) drive(1'b0, 1'b0);
    check("gated_env", int'(bus.env), 1);
    check("gated_state", int'(bus.state_o), S_ATT);

    // Reset mid-attack at 0x40 with gate held high
    ticks(63 * 9);
    check("mid_attack_env", int'(bus.env), 8'h40);
    drive(1'b1, 1'b1);
    check("mid_rst_env", int'(bus.env), 0);
    check("mid_rst_state", int'(bus.state_o), S_REL);
    ticks(1);
    check("post_rst_attack", int'(bus.state_o), S_ATT);

    // Random traffic
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 299) == 0) gate = ~gate;
      if ($urandom_range(0, 199) == 0) a_nib = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) d_nib = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) r_nib = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) s_nib = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
    end

    @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
